fp_align_unit: RTL and testbench

- Front end of the MAC datapath; the inverse of the normalization stage.
- Collects a group of N_OPS sign/exponent/mantissa operands over a valid/ready stream and finds the group's maximum exponent.
- Emits each operand as a right-aligned, two's-complement fixed-point value against that maximum exponent, ready for signed accumulation.
- Downstream normalization consumes the accumulated sum together with out_exp_max.

---
 rtl/fp_align_unit_pkg.sv | 14 +
 rtl/fp_align_shifter.sv | 41 ++++
 rtl/fp_align_unit.sv | 158 +++++++++++++++
 tb/tb_fp_align_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_align_unit_pkg.sv
// Shared MAC datapath definitions: operand field widths and the align/normalize FSM states.
package fp_align_unit_pkg;

  localparam int MAC_EXP_W   = 6;
  localparam int MAC_MANT_W  = 11;
  localparam int MAC_GUARD_W = 4;
  localparam int MAC_OUT_W   = MAC_MANT_W + MAC_GUARD_W + 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

endpackage

// File: rtl/fp_align_shifter.sv
// Aligns one operand to the group maximum exponent: truncating right shift, saturation, then negate.
module fp_align_shifter
  import fp_align_unit_pkg::*;
#(
  parameter int EXP_W   = MAC_EXP_W,
  parameter int MANT_W  = MAC_MANT_W,
  parameter int GUARD_W = MAC_GUARD_W
) (
  input  logic [EXP_W-1:0]              exp_max,
  input  logic [EXP_W-1:0]              exp,
  input  logic                          sign,
  input  logic [MANT_W-1:0]             mant,
  output logic [MANT_W+GUARD_W:0]       data
);

  localparam int OUT_W = MANT_W + GUARD_W + 1;
  localparam logic [EXP_W:0] SHIFT_LIM = (EXP_W+1)'(MANT_W + GUARD_W);

  logic [EXP_W:0] diff_s;
  logic [OUT_W-1:0] ext_s;
  logic [OUT_W-1:0] mag_s;

  // Sign-extended difference, shift with saturation, two's-complement negate.
  always_comb begin
    diff_s = {exp_max[EXP_W-1], exp_max} - {exp[EXP_W-1], exp};
    ext_s  = {1'b0, mant, {GUARD_W{1'b0}}};
    if (mant == {MANT_W{1'b0}}) begin
      mag_s = {OUT_W{1'b0}};
    end else if (diff_s[EXP_W] || (diff_s >= SHIFT_LIM)) begin
      mag_s = {OUT_W{1'b0}};
    end else begin
      mag_s = ext_s >> diff_s;
    end
    if (sign) begin
      data = {OUT_W{1'b0}} - mag_s;
    end else begin
      data = mag_s;
    end
  end

endmodule

// File: rtl/fp_align_unit.sv
// Collects N_OPS float operands, tracks the group max exponent and streams them out as aligned
// two's-complement fixed-point values.
module fp_align_unit
  import fp_align_unit_pkg::*;
#(
  parameter int N_OPS   = 4,
  parameter int EXP_W   = MAC_EXP_W,
  parameter int MANT_W  = MAC_MANT_W,
  parameter int GUARD_W = MAC_GUARD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sign,
  input  logic [EXP_W-1:0]            in_exp,
  input  logic [MANT_W-1:0]           in_mant,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MANT_W+GUARD_W:0]     out_data,
  output logic [EXP_W-1:0]            out_exp_max,
  output logic [$clog2(N_OPS)-1:0]    out_idx,
  output logic                        out_last
);

  localparam int OUT_W = MANT_W + GUARD_W + 1;
  localparam int IDX_W = $clog2(N_OPS);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [EXP_W-1:0]   max_r;
  logic               seen_r;
  logic               sign_buf_r [N_OPS];
  logic [EXP_W-1:0]   exp_buf_r  [N_OPS];
  logic [MANT_W-1:0]  mant_buf_r [N_OPS];

  logic               acc_s;
  logic               seen_s;
  logic               seen_nxt_s;
  logic [EXP_W-1:0]   base_max_s;
  logic [EXP_W-1:0]   max_nxt_s;
  logic [EXP_W-1:0]   shf_max_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [OUT_W-1:0]   shf_data_s;

  // Accept qualification, running max for the next cycle and the entry to align next.
  always_comb begin
    acc_s      = (state_r == COLLECT) && in_valid;
    seen_s     = (idx_r != IDX_ZERO) && seen_r;
    base_max_s = (idx_r == IDX_ZERO) ? {EXP_W{1'b0}} : max_r;
    max_nxt_s  = base_max_s;
    seen_nxt_s = seen_s;
    if (acc_s && (in_mant != {MANT_W{1'b0}})) begin
      seen_nxt_s = 1'b1;
      if (!seen_s || ($signed(in_exp) > $signed(base_max_s))) begin
        max_nxt_s = in_exp;
      end else begin
        max_nxt_s = base_max_s;
      end
    end else begin
      max_nxt_s  = base_max_s;
      seen_nxt_s = seen_s;
    end
    if (state_r == EMIT) begin
      sel_idx_s = idx_r + IDX_ONE;
      shf_max_s = max_r;
    end else begin
      sel_idx_s = IDX_ZERO;
      shf_max_s = max_nxt_s;
    end
  end

  fp_align_shifter #(
    .EXP_W   (EXP_W),
    .MANT_W  (MANT_W),
    .GUARD_W (GUARD_W)
  ) u_shifter (
    .exp_max (shf_max_s),
    .exp     (exp_buf_r[sel_idx_s]),
    .sign    (sign_buf_r[sel_idx_s]),
    .mant    (mant_buf_r[sel_idx_s]),
    .data    (shf_data_s)
  );

  // Operand buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (acc_s) begin
      sign_buf_r[idx_r] <= in_sign;
      exp_buf_r[idx_r]  <= in_exp;
      mant_buf_r[idx_r] <= in_mant;
    end
  end

  // Collect/emit FSM with registered handshake and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COLLECT;
      idx_r       <= IDX_ZERO;
      max_r       <= {EXP_W{1'b0}};
      seen_r      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= {OUT_W{1'b0}};
      out_exp_max <= {EXP_W{1'b0}};
      out_idx     <= IDX_ZERO;
      out_last    <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (acc_s) begin
            max_r  <= max_nxt_s;
            seen_r <= seen_nxt_s;
            if (idx_r == IDX_LAST) begin
              idx_r       <= IDX_ZERO;
              state_r     <= EMIT;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_data    <= shf_data_s;
              out_exp_max <= max_nxt_s;
              out_idx     <= IDX_ZERO;
              out_last    <= 1'b0;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_r == IDX_LAST) begin
              idx_r     <= IDX_ZERO;
              state_r   <= COLLECT;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_data  <= {OUT_W{1'b0}};
              out_idx   <= IDX_ZERO;
              out_last  <= 1'b0;
            end else begin
              idx_r    <= idx_r + IDX_ONE;
              out_idx  <= idx_r + IDX_ONE;
              out_data <= shf_data_s;
              out_last <= ((idx_r + IDX_ONE) == IDX_LAST);
            end
          end
        end
        default: begin
          state_r   <= COLLECT;
          idx_r     <= IDX_ZERO;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_unit.sv
// Self-checking bench for fp_align_unit: directed groups plus random groups against an integer model.
module tb_fp_align_unit;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [5:0]  in_exp = 6'd0;
  logic [10:0] in_mant = 11'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [5:0]  out_exp_max;
  logic [1:0]  out_idx;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int g_sign [N];
  int g_exp  [N];
  int g_mant [N];

  always #5 clk = ~clk;

  fp_align_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_exp_max (out_exp_max),
    .out_idx     (out_idx),
    .out_last    (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int s, input int e, input int m);
    g_sign[i] = s;
    g_exp[i]  = e;
    g_mant[i] = m;
  endtask

  function automatic int model_max();
    int  emax = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g_mant[i] != 0) begin
        if (!seen || g_exp[i] > emax) emax = g_exp[i];
        seen = 1'b1;
      end
    end
    return emax;
  endfunction

  function automatic logic [31:0] model_data(input int i, input int emax);
    int diff;
    int mag;
    int v;
    if (g_mant[i] == 0) return 32'h0;
    diff = emax - g_exp[i];
    mag  = (diff >= 15) ? 0 : ((g_mant[i] * 16) >> diff);
    v    = (g_sign[i] != 0) ? -mag : mag;
    return {16'h0, v[15:0]};
  endfunction

  // Feeds g_* as one group (in_valid kept high through emit), then drains it with an optional stall.
  task automatic run_group(input int stall_at, input int stall_len);
    int emax;
    logic [31:0] emax6;
    emax  = model_max();
    emax6 = 32'(emax & 63);
    chk("in_ready_collect", 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_sign  = g_sign[i][0];
      in_exp   = g_exp[i][5:0];
      in_mant  = g_mant[i][10:0];
      if (i > 0) chk("no_out_collect", 32'(out_valid), 32'd0);
      tick();
    end
    in_sign = 1'b0;
    in_exp  = 6'd31;
    in_mant = 11'h7FF;
    for (int i = 0; i < N; i++) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("in_ready_emit", 32'(in_ready), 32'd0);
      chk("out_data", 32'(out_data), model_data(i, emax));
      chk("out_idx", 32'(out_idx), 32'(i));
      chk("out_last", 32'(out_last), (i == N - 1) ? 32'd1 : 32'd0);
      chk("out_exp_max", 32'(out_exp_max), emax6);
      if (i == stall_at && stall_len > 0) begin
        out_ready = 1'b0;
        for (int c = 0; c < stall_len; c++) begin
          tick();
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_data", 32'(out_data), model_data(i, emax));
          chk("stall_idx", 32'(out_idx), 32'(i));
          chk("stall_exp_max", 32'(out_exp_max), emax6);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("in_ready_reassert", 32'(in_ready), 32'd1);
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_exp_max", 32'(out_exp_max), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;

    set_op(0, 0, 3, 'h400); set_op(1, 1, 1, 'h600); set_op(2, 0, 3, 'h7FF); set_op(3, 0, -2, 'h400);
    run_group(-1, 0);
    set_op(0, 0, 5, 'h7FF); set_op(1, 0, -9, 'h7FF); set_op(2, 0, -10, 'h7FF); set_op(3, 1, 5, 'h400);
    run_group(-1, 0);
    set_op(0, 1, 20, 0); set_op(1, 0, 2, 'h400); set_op(2, 1, -5, 0); set_op(3, 0, 1, 'h400);
    run_group(-1, 0);
    set_op(0, 1, 7, 0); set_op(1, 0, -3, 0); set_op(2, 1, 31, 0); set_op(3, 0, 0, 0);
    run_group(-1, 0);
    set_op(0, 1, -4, 'h555); set_op(1, 0, -1, 'h7FF); set_op(2, 1, -6, 'h400); set_op(3, 0, -1, 'h401);
    run_group(1, 5);

    // Reset after two accepts of large-exponent operands; none may leak into the next group.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 6'd30;
      in_mant  = 11'h7FF;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_exp_max", 32'(out_exp_max), 32'd0);
    set_op(0, 0, -2, 'h400); set_op(1, 1, 4, 'h500); set_op(2, 0, 1, 'h7FF); set_op(3, 1, -8, 'h600);
    run_group(-1, 0);

    // Random groups; consecutive run_group calls keep in_valid high between groups.
    for (int g = 0; g < 30; g++) begin
      for (int i = 0; i < N; i++) begin
        int m;
        m = ($urandom_range(0, 3) == 0) ? 0 : int'(11'h400 | 11'($urandom_range(0, 1023)));
        set_op(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 63)) - 32, m);
        if (g % 3 == 0) g_exp[i] = int'($urandom_range(0, 20)) - 10;
      end
      run_group((g % 2 == 0) ? int'($urandom_range(0, 3)) : -1, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
